// File: rtl/fe_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential field-element add/sub unit.
interface fe_addsub_seq_if #(
  parameter int N_LIMBS = 10,
  parameter int LIMB_W  = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      op;
  logic [N_LIMBS*LIMB_W-1:0] f;
  logic [N_LIMBS*LIMB_W-1:0] g;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_LIMBS*LIMB_W-1:0] h;
  logic                      ovf;

  modport master (
    output in_valid, op, f, g, out_ready,
    input  in_ready, out_valid, h, ovf
  );

  modport slave (
    input  in_valid, op, f, g, out_ready,
    output in_ready, out_valid, h, ovf
  );
endinterface

// File: rtl/fe_addsub_seq.sv
// Limb-wise field-element add/subtract, LANES limbs per cycle, no inter-limb carry.
// Flags any limb whose exact signed result does not fit in LIMB_W bits.
module fe_addsub_seq #(
  parameter int N_LIMBS = 10,
  parameter int LIMB_W  = 32,
  parameter int LANES   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fe_addsub_seq_if.slave bus
);
  localparam int LANES_SAFE = (LANES < 1) ? 1 : LANES;
  localparam int S          = N_LIMBS / LANES_SAFE;
  localparam int JW         = (S > 1) ? $clog2(S) : 1;
  localparam int LW         = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;

  generate
    if ((LANES < 1) || ((N_LIMBS % LANES_SAFE) != 0)) begin : g_bad_lanes
      $error("fe_addsub_seq: LANES must be >= 1 and divide N_LIMBS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [JW-1:0]     j_reg;
  logic              op_reg;
  logic              ovf_reg;
  logic [LIMB_W-1:0] f_reg [N_LIMBS];
  logic [LIMB_W-1:0] g_reg [N_LIMBS];
  logic [LIMB_W-1:0] h_reg [N_LIMBS];

  logic              in_ready_int;
  logic              out_valid_int;
  logic              last_chunk;
  logic [LW-1:0]     base;
  logic [LIMB_W-1:0] lane_h   [LANES_SAFE];
  logic [LANES_SAFE-1:0] lane_ovf;

  assign last_chunk = (j_reg == JW'(S - 1));
  assign base       = LW'(int'(j_reg) * LANES_SAFE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshake outputs decode from state only; inputs affect just the next state
  always_comb begin
    state_next    = state_reg;
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_int = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        out_valid_int = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < LANES_SAFE; gi++) begin : g_lane
      logic [LIMB_W-1:0] fl, gl;
      logic [LIMB_W:0]   a, b, r;
      assign fl = f_reg[base + LW'(gi)];
      assign gl = g_reg[base + LW'(gi)];
      assign a  = {fl[LIMB_W-1], fl};
      assign b  = {gl[LIMB_W-1], gl};
      assign r  = op_reg ? (a - b) : (a + b);
      assign lane_h[gi]   = r[LIMB_W-1:0];
      // Exact result fits only if the extra sign bit agrees with the limb MSB
      assign lane_ovf[gi] = r[LIMB_W] ^ r[LIMB_W-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_reg   <= '0;
      op_reg  <= 1'b0;
      ovf_reg <= 1'b0;
      for (int k = 0; k < N_LIMBS; k++) begin
        f_reg[k] <= '0;
        g_reg[k] <= '0;
        h_reg[k] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            j_reg   <= '0;
            op_reg  <= bus.op;
            ovf_reg <= 1'b0;
            for (int k = 0; k < N_LIMBS; k++) begin
              f_reg[k] <= bus.f[k*LIMB_W +: LIMB_W];
              g_reg[k] <= bus.g[k*LIMB_W +: LIMB_W];
              h_reg[k] <= '0;
            end
          end
        end
        RUN: begin
          for (int k = 0; k < LANES_SAFE; k++) begin
            h_reg[base + LW'(k)] <= lane_h[k];
          end
          ovf_reg <= ovf_reg | (|lane_ovf);
          j_reg   <= j_reg + JW'(1);
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_LIMBS; gi++) begin : g_pack
      assign bus.h[gi*LIMB_W +: LIMB_W] = h_reg[gi];
    end
  endgenerate

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_fe_addsub_seq.sv
// Directed bench for fe_addsub_seq: main LANES=2 instance plus LANES 1/5/10 for latency sweep.
module tb_fe_addsub_seq;
  localparam int N  = 10;
  localparam int W  = 32;
  localparam int TW = N * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fe_addsub_seq_if #(.N_LIMBS(N), .LIMB_W(W)) bus2 ();
  fe_addsub_seq_if #(.N_LIMBS(N), .LIMB_W(W)) bus1 ();
  fe_addsub_seq_if #(.N_LIMBS(N), .LIMB_W(W)) bus5 ();
  fe_addsub_seq_if #(.N_LIMBS(N), .LIMB_W(W)) bus10 ();

  fe_addsub_seq #(.N_LIMBS(N), .LIMB_W(W), .LANES(2))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  fe_addsub_seq #(.N_LIMBS(N), .LIMB_W(W), .LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  fe_addsub_seq #(.N_LIMBS(N), .LIMB_W(W), .LANES(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
  fe_addsub_seq #(.N_LIMBS(N), .LIMB_W(W), .LANES(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one operation on the LANES=2 unit; returns 1 ns after the accept edge
  task automatic issue(input string tag, input logic [TW-1:0] fv, input logic [TW-1:0] gv, input logic opv);
    check({tag, "_ready"}, TW'(bus2.in_ready), TW'(1));
    bus2.f = fv; bus2.g = gv; bus2.op = opv; bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    bus2.f = ~fv; bus2.g = ~gv; bus2.op = ~opv;
    $display("issue %s op=%0d", tag, opv);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus2.out_valid && lat < 30);
  endtask

  task automatic consume(input string tag);
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready = 1'b0;
    check({tag, "_rdy_after"}, TW'(bus2.in_ready), TW'(1));
    check({tag, "_vld_after"}, TW'(bus2.out_valid), TW'(0));
  endtask

  task automatic run_one(input string tag, input logic [TW-1:0] fv, input logic [TW-1:0] gv,
                         input logic opv, input logic [TW-1:0] exp_h, input logic exp_ovf);
    int lat;
    issue(tag, fv, gv, opv);
    wait_done(lat);
    check({tag, "_lat"}, TW'(lat), TW'(5));
    check({tag, "_h"}, bus2.h, exp_h);
    check({tag, "_ovf"}, TW'(bus2.ovf), TW'(exp_ovf));
    $display("result %s lat=%0d ovf=%0d h=%0h", tag, lat, bus2.ovf, bus2.h);
    consume(tag);
  endtask

  initial begin
    int lat;
    int lat1, lat2, lat5, lat10;
    logic [TW-1:0] sf, sg, sh;

    bus2.in_valid = 0;  bus2.op = 0;  bus2.f = '0;  bus2.g = '0;  bus2.out_ready = 0;
    bus1.in_valid = 0;  bus1.op = 0;  bus1.f = '0;  bus1.g = '0;  bus1.out_ready = 0;
    bus5.in_valid = 0;  bus5.op = 0;  bus5.f = '0;  bus5.g = '0;  bus5.out_ready = 0;
    bus10.in_valid = 0; bus10.op = 0; bus10.f = '0; bus10.g = '0; bus10.out_ready = 0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", TW'(bus2.in_ready), TW'(1));
    check("rst_out_valid", TW'(bus2.out_valid), TW'(0));
    check("rst_h", bus2.h, '0);
    check("rst_ovf", TW'(bus2.ovf), TW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", TW'(bus2.in_ready), TW'(1));

    run_one("sub_5_3", {10{32'd5}}, {10{32'd3}}, 1'b1, {10{32'd2}}, 1'b0);
    run_one("neg_wrap", '0, {288'd0, 32'd1}, 1'b1, {288'd0, 32'hFFFFFFFF}, 1'b0);
    run_one("add_ovf", {32'h7FFFFFFF, 288'd0}, {32'd1, 288'd0}, 1'b0, {32'h80000000, 288'd0}, 1'b1);
    run_one("clean_add", {10{32'd1}}, {10{32'd2}}, 1'b0, {10{32'd3}}, 1'b0);
    run_one("sub_ovf", {288'd0, 32'h80000000}, {288'd0, 32'd1}, 1'b1, {288'd0, 32'h7FFFFFFF}, 1'b1);

    // Backpressure in DONE while new operands are offered
    issue("bp", {10{32'd7}}, {10{32'd4}}, 1'b0);
    wait_done(lat);
    check("bp_lat", TW'(lat), TW'(5));
    bus2.f = {10{32'd100}}; bus2.g = {10{32'd100}}; bus2.op = 1'b0; bus2.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_h", bus2.h, {10{32'd11}});
      check("bp_hold_flags", TW'({bus2.in_ready, bus2.out_valid, bus2.ovf}), TW'(3'b010));
      $display("backpressure cycle %0d in_ready=%0d out_valid=%0d", c, bus2.in_ready, bus2.out_valid);
    end
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready = 1'b0;
    check("bp_release_ready", TW'(bus2.in_ready), TW'(1));
    check("bp_release_valid", TW'(bus2.out_valid), TW'(0));
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    check("bp_next_accept", TW'(bus2.in_ready), TW'(0));
    wait_done(lat);
    check("bp2_lat", TW'(lat), TW'(5));
    check("bp2_h", bus2.h, {10{32'd200}});
    $display("result bp2 lat=%0d h=%0h", lat, bus2.h);
    consume("bp2");

    // Reset in the middle of RUN, after two chunks have been written
    issue("mid_rst", {10{32'h7FFFFFFF}}, {10{32'd1}}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_partial_ovf", TW'(bus2.ovf), TW'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_h", bus2.h, '0);
    check("mid_rst_ovf", TW'(bus2.ovf), TW'(0));
    check("mid_rst_valid", TW'(bus2.out_valid), TW'(0));
    check("mid_rst_ready", TW'(bus2.in_ready), TW'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_ready", TW'(bus2.in_ready), TW'(1));
    check("mid_rel_valid", TW'(bus2.out_valid), TW'(0));
    check("mid_rel_h", bus2.h, '0);
    $display("reset mid-run released");

    // LANES sweep: same operands to all four units
    sf = {32'd100, 32'd90, 32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
    sg = {32'd10, 32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    sh = {32'd90, 32'd81, 32'd72, 32'd63, 32'd54, 32'd45, 32'd36, 32'd27, 32'd18, 32'd9};
    bus2.f = sf;  bus2.g = sg;  bus2.op = 1'b1;  bus2.in_valid = 1'b1;
    bus1.f = sf;  bus1.g = sg;  bus1.op = 1'b1;  bus1.in_valid = 1'b1;
    bus5.f = sf;  bus5.g = sg;  bus5.op = 1'b1;  bus5.in_valid = 1'b1;
    bus10.f = sf; bus10.g = sg; bus10.op = 1'b1; bus10.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 0; bus1.in_valid = 0; bus5.in_valid = 0; bus10.in_valid = 0;
    bus2.f = '0; bus1.f = '0; bus5.f = '0; bus10.f = '0;
    lat1 = 0; lat2 = 0; lat5 = 0; lat10 = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (bus1.out_valid && lat1 == 0)   lat1 = k;
      if (bus2.out_valid && lat2 == 0)   lat2 = k;
      if (bus5.out_valid && lat5 == 0)   lat5 = k;
      if (bus10.out_valid && lat10 == 0) lat10 = k;
    end
    check("sweep_lat_l1", TW'(lat1), TW'(10));
    check("sweep_lat_l2", TW'(lat2), TW'(5));
    check("sweep_lat_l5", TW'(lat5), TW'(2));
    check("sweep_lat_l10", TW'(lat10), TW'(1));
    check("sweep_h_l1", bus1.h, sh);
    check("sweep_h_l2", bus2.h, sh);
    check("sweep_h_l5", bus5.h, sh);
    check("sweep_h_l10", bus10.h, sh);
    $display("sweep lat l1=%0d l2=%0d l5=%0d l10=%0d", lat1, lat2, lat5, lat10);
    bus2.out_ready = 1; bus1.out_ready = 1; bus5.out_ready = 1; bus10.out_ready = 1;
    @(posedge clk); #1;
    bus2.out_ready = 0; bus1.out_ready = 0; bus5.out_ready = 0; bus10.out_ready = 0;
    check("sweep_l10_idle", TW'(bus10.in_ready), TW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
